adder_error_profiler: RTL and testbench
=======================================

Name: adder_error_profiler

Overview:
- Sequencer that sweeps every operand pair through an exact adder and an approximate adder held outside the block, and gathers error statistics.
- Sweeps all 2^(2*WIDTH) pairs (4096 for WIDTH=6), compares the two sums and accumulates error count, maximum error distance and summed error distance.
- Sits beside the adder library as the characterisation harness.
- Shares one operand bus between both adders under test (AUTs).

Parameters:
- WIDTH, 6, operand width of the AUTs; sums are WIDTH+1 bits.
- LAT, 0, register latency of the AUTs in cycles, from op_a/op_b to y_exact/y_approx; range 0..7.
- SUM_W, 20, width of the summed error-distance accumulator.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a sweep; sampled only in IDLE or DONE.
- abort  in  1  stops the sweep; honoured in RUN and DRAIN.
- op_a  out  WIDTH  operand A driven to both AUTs.
- op_b  out  WIDTH  operand B driven to both AUTs.
- y_exact  in  WIDTH+1  exact sum, returned LAT cycles after its operands.
- y_approx  in  WIDTH+1  approximate sum, same alignment as y_exact.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE; stays high until the next accepted start.
- err_count  out  2*WIDTH+1  number of pairs with y_exact != y_approx.
- max_ed  out  WIDTH+1  largest |y_exact - y_approx| seen.
- sum_ed  out  SUM_W  sum of |y_exact - y_approx|; wraps modulo 2^SUM_W.

Behaviour:
- Reset (async, rst_n low): state IDLE; op_a, op_b, busy, done, err_count, max_ed and sum_ed all 0; index counter and valid pipeline cleared.
- States are IDLE, RUN, DRAIN and DONE.
- IDLE/DONE to RUN:
  - Happens on any clock edge where start=1.
  - On that edge the index is cleared to 0, all three metrics are cleared to 0 and done falls.
- RUN:
  - An index register idx is 2*WIDTH bits wide; op_a = idx[2*WIDTH-1:WIDTH] and op_b = idx[WIDTH-1:0], both driven from registers.
  - idx increments by one every cycle, so one pair is issued per cycle.
  - Order is op_b fastest: (0,0), (0,1) … (0,63), (1,0) … (63,63).
  - After the cycle in which idx is all ones, the FSM goes to DRAIN, or straight to DONE when LAT=0.
  - idx then wraps to 0, and op_a/op_b return to 0.
- Valid tracking:
  - An issue-valid bit is high in each RUN cycle.
  - It is delayed by LAT stages; for LAT=0 the response is sampled in the same cycle the operands are issued.
  - A delayed-valid of 1 at a clock edge commits one comparison.
  - Responses are never sampled without a matching delayed-valid.
- Comparison, per committed pair:
  - ed = |y_exact - y_approx|, computed unsigned at WIDTH+1 bits.
  - If ed != 0, err_count increments.
  - If ed > max_ed, max_ed is loaded with ed.
  - sum_ed = sum_ed + ed, zero-extended, wrapping.
- DRAIN: lasts exactly LAT cycles so that every in-flight result is committed, then the FSM goes to DONE.
- Latency: from the start edge to the done-rising edge is 2^(2*WIDTH) + LAT cycles (4096 for defaults).
- DONE: metrics are frozen and done=1 until a new start.
- abort in RUN or DRAIN:
  - Next state is IDLE; busy falls and done stays 0.
  - The valid pipeline is flushed, so in-flight results are discarded.
  - Metrics hold their partial values.
- start while busy is ignored.
- start and abort together in RUN: abort wins.
- abort in IDLE or DONE: no effect.
- rst_n falling mid-sweep: immediate return to the reset values above, with no partial metrics kept.
- Outputs change only on clock edges, except the reset clear.

Test Plan:
- AUT y_approx tied to y_exact, LAT=0, pulse start → done rises 4096 cycles after the start edge; err_count=0, max_ed=0, sum_ed=0; busy high for exactly 4096 cycles.
- y_approx = y_exact with bit0 forced to 0 → err_count=2048, max_ed=1, sum_ed=2048.
- y_approx tied to 0 → err_count=4095, max_ed=126, sum_ed=258048.
- LAT=2 with both AUT paths registered twice and y_approx = y_exact:
  - Required: err_count=0 and done 4098 cycles after start.
  - Repeat with y_approx forced to 0 only when op_a=63 and op_b=63 at issue: err_count=1, max_ed=126, sum_ed=126 (checks last-pair drain).
- Abort, bit0-forced AUT: assert abort when op_a=0 and op_b=10 (idx=10) → busy=0 and done=0 on the next cycle; err_count=5, sum_ed=5, max_ed=1 (pairs 0..9 committed).
  - Then pulse start → metrics clear and a full sweep gives 2048.
- Start pulses during RUN are ignored and the sweep completes normally.
- rst_n low at idx=2000 → all outputs are 0 immediately.
- A start after reset gives full-sweep results identical to a clean run.

Source files
------------

// File: rtl/adder_error_profiler.sv
// Characterisation sequencer: sweeps every operand pair through an exact and an
// approximate adder and accumulates error count, max and summed error distance.
module adder_error_profiler #(
   parameter int WIDTH = 6,
   parameter int LAT   = 0,
   parameter int SUM_W = 20
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   output logic [WIDTH-1:0]     op_a,
   output logic [WIDTH-1:0]     op_b,
   input  logic [WIDTH:0]       y_exact,
   input  logic [WIDTH:0]       y_approx,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH:0]     err_count,
   output logic [WIDTH:0]       max_ed,
   output logic [SUM_W-1:0]     sum_ed
);

   localparam int IW = 2 * WIDTH;
   localparam int PW = (LAT > 0) ? LAT : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state_q;
   logic [IW-1:0]       idx_q;
   logic [PW-1:0]       vpipe_q;
   logic [PW-1:0]       vpipe_d;
   logic [2:0]          drain_q;
   logic                busy_q;
   logic                done_q;
   logic [2*WIDTH:0]    err_count_q;
   logic [2*WIDTH:0]    err_count_d;
   logic [WIDTH:0]      max_ed_q;
   logic [WIDTH:0]      max_ed_d;
   logic [SUM_W-1:0]    sum_ed_q;
   logic [SUM_W-1:0]    sum_ed_d;
   logic [WIDTH:0]      ed_s;
   logic                issue_s;
   logic                dvalid_s;
   logic                commit_s;

   // Valid alignment and per-pair metric update; an aborting cycle commits nothing.
   always_comb begin
      issue_s    = (state_q == S_RUN);
      vpipe_d    = vpipe_q << 1;
      vpipe_d[0] = issue_s;
      if (LAT == 0) begin
         dvalid_s = issue_s;
      end else begin
         dvalid_s = vpipe_q[PW-1];
      end
      commit_s = dvalid_s & ~abort;
      if (y_exact >= y_approx) begin
         ed_s = y_exact - y_approx;
      end else begin
         ed_s = y_approx - y_exact;
      end
      err_count_d = err_count_q;
      max_ed_d    = max_ed_q;
      sum_ed_d    = sum_ed_q + SUM_W'(ed_s);
      if (ed_s != '0) begin
         err_count_d = err_count_q + (2*WIDTH+1)'(1);
      end else begin
         err_count_d = err_count_q;
      end
      if (ed_s > max_ed_q) begin
         max_ed_d = ed_s;
      end else begin
         max_ed_d = max_ed_q;
      end
   end

   // Sweep FSM with registered status outputs and metric accumulators.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         vpipe_q     <= '0;
         drain_q     <= 3'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_count_q <= '0;
         max_ed_q    <= '0;
         sum_ed_q    <= '0;
      end else begin
         if (commit_s) begin
            err_count_q <= err_count_d;
            max_ed_q    <= max_ed_d;
            sum_ed_q    <= sum_ed_d;
         end
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q     <= S_RUN;
                  idx_q       <= '0;
                  vpipe_q     <= '0;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  err_count_q <= '0;
                  max_ed_q    <= '0;
                  sum_ed_q    <= '0;
               end
            end
            S_RUN: begin
               if (abort) begin
                  state_q <= S_IDLE;
                  idx_q   <= '0;
                  vpipe_q <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end else begin
                  idx_q   <= idx_q + IW'(1);
                  vpipe_q <= vpipe_d;
                  drain_q <= 3'd0;
                  if (idx_q == '1) begin
                     if (LAT == 0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= S_DRAIN;
                     end
                  end
               end
            end
            S_DRAIN: begin
               if (abort) begin
                  state_q <= S_IDLE;
                  vpipe_q <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end else begin
                  vpipe_q <= vpipe_d;
                  if (drain_q == 3'(LAT - 1)) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     drain_q <= drain_q + 3'd1;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign op_a      = idx_q[IW-1:WIDTH];
   assign op_b      = idx_q[WIDTH-1:0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign err_count = err_count_q;
   assign max_ed    = max_ed_q;
   assign sum_ed    = sum_ed_q;

endmodule

// File: tb/tb_adder_error_profiler.sv
// Directed bench for adder_error_profiler: a combinational-AUT instance (LAT=0)
// and a twice-registered-AUT instance (LAT=2), checked against a sweep model.
module tb_adder_error_profiler;

   typedef struct {
      int err;
      int mx;
      int sum;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start0, abort0, start2, abort2;
   int          mode;
   int          n_checks = 0;
   int          n_fail = 0;
   exp_t        exp_q[$];

   logic [5:0]  op_a0, op_b0, op_a2, op_b2;
   logic [6:0]  y_ex0, y_ap0, y_ex2, y_ap2, ex_p1, ap_p1;
   logic        busy0, done0, busy2, done2;
   logic [12:0] err0, err2;
   logic [6:0]  max0, max2;
   logic [19:0] sum0, sum2;

   always #5 clk = ~clk;

   function automatic logic [6:0] aut(input int md, input logic [5:0] a, input logic [5:0] b);
      logic [6:0] s;
      s = {1'b0, a} + {1'b0, b};
      case (md)
         1: s[0] = 1'b0;
         2: s = 7'd0;
         3: if (a == 6'd63 && b == 6'd63) s = 7'd0;
         default: ;
      endcase
      return s;
   endfunction

   function automatic exp_t model(input int md, input int npairs);
      exp_t e;
      int ex, ap, ed;
      e.err = 0; e.mx = 0; e.sum = 0;
      for (int i = 0; i < npairs; i++) begin
         ex = (i >> 6) + (i & 63);
         ap = int'(aut(md, 6'(i >> 6), 6'(i & 63)));
         ed = (ex > ap) ? ex - ap : ap - ex;
         if (ed != 0) e.err++;
         if (ed > e.mx) e.mx = ed;
         e.sum = (e.sum + ed) & 32'h000F_FFFF;
      end
      return e;
   endfunction

   assign y_ex0 = {1'b0, op_a0} + {1'b0, op_b0};
   assign y_ap0 = aut(mode, op_a0, op_b0);

   always @(posedge clk) begin
      ex_p1 <= {1'b0, op_a2} + {1'b0, op_b2};
      ap_p1 <= aut(mode, op_a2, op_b2);
      y_ex2 <= ex_p1;
      y_ap2 <= ap_p1;
   end

   adder_error_profiler #(.WIDTH(6), .LAT(0), .SUM_W(20)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
      .op_a(op_a0), .op_b(op_b0), .y_exact(y_ex0), .y_approx(y_ap0),
      .busy(busy0), .done(done0), .err_count(err0), .max_ed(max0), .sum_ed(sum0));

   adder_error_profiler #(.WIDTH(6), .LAT(2), .SUM_W(20)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
      .op_a(op_a2), .op_b(op_b2), .y_exact(y_ex2), .y_approx(y_ap2),
      .busy(busy2), .done(done2), .err_count(err2), .max_ed(max2), .sum_ed(sum2));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic check_zero(input int which);
      if (which == 0) begin
         check("rst_op", {26'd0, op_a0, op_b0}, 32'd0);
         check("rst_flags", {30'd0, busy0, done0}, 32'd0);
         check("rst_err", {19'd0, err0}, 32'd0);
         check("rst_max", {25'd0, max0}, 32'd0);
         check("rst_sum", {12'd0, sum0}, 32'd0);
      end else begin
         check("rst2_op", {26'd0, op_a2, op_b2}, 32'd0);
         check("rst2_flags", {30'd0, busy2, done2}, 32'd0);
         check("rst2_err", {19'd0, err2}, 32'd0);
         check("rst2_max", {25'd0, max2}, 32'd0);
         check("rst2_sum", {12'd0, sum2}, 32'd0);
      end
   endtask

   task automatic pulse_start(input int which);
      @(negedge clk);
      if (which == 0) start0 = 1'b1; else start2 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start2 = 1'b0;
   endtask

   task automatic sweep(input int which, input int md, input int exp_cyc, input bit poke);
      exp_t e;
      int cyc, bsy;
      bit fin;
      mode = md;
      exp_q.push_back(model(md, 4096));
      pulse_start(which);
      check("start_clear_err", (which == 0) ? {19'd0, err0} : {19'd0, err2}, 32'd0);
      bsy = ((which == 0) ? busy0 : busy2) ? 1 : 0;
      cyc = 0;
      fin = 1'b0;
      while (!fin && cyc < 5000) begin
         if (poke && cyc == 100) begin
            if (which == 0) start0 = 1'b1; else start2 = 1'b1;
         end else begin
            start0 = 1'b0;
            start2 = 1'b0;
         end
         @(posedge clk);
         cyc++;
         #1;
         if ((which == 0) ? done0 : done2) fin = 1'b1;
         else if ((which == 0) ? busy0 : busy2) bsy++;
      end
      start0 = 1'b0;
      start2 = 1'b0;
      check("done_latency", cyc, exp_cyc);
      check("busy_cycles", bsy, exp_cyc);
      e = exp_q.pop_front();
      check("err_count", (which == 0) ? {19'd0, err0} : {19'd0, err2}, e.err);
      check("max_ed", (which == 0) ? {25'd0, max0} : {25'd0, max2}, e.mx);
      check("sum_ed", (which == 0) ? {12'd0, sum0} : {12'd0, sum2}, e.sum);
      @(negedge clk);
      if (which == 0) abort0 = 1'b1; else abort2 = 1'b1;
      @(posedge clk);
      #1;
      abort0 = 1'b0;
      abort2 = 1'b0;
      check("done_holds", (which == 0) ? {31'd0, done0} : {31'd0, done2}, 32'd1);
      check("frozen_err", (which == 0) ? {19'd0, err0} : {19'd0, err2}, e.err);
   endtask

   initial begin
      exp_t e;
      int w;
      rst_n = 1'b0;
      start0 = 1'b0; abort0 = 1'b0; start2 = 1'b0; abort2 = 1'b0;
      mode = 0;
      #1;
      check_zero(0);
      check_zero(1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      sweep(0, 0, 4096, 1'b0);
      sweep(0, 1, 4096, 1'b0);
      sweep(0, 2, 4096, 1'b0);
      sweep(2, 0, 4098, 1'b0);
      sweep(2, 3, 4098, 1'b0);

      // abort once idx reaches 10: only pairs 0..9 count
      mode = 1;
      exp_q.push_back(model(1, 10));
      pulse_start(0);
      w = 0;
      while (!(op_a0 == 6'd0 && op_b0 == 6'd10) && w < 100) begin
         @(posedge clk);
         #1;
         w++;
      end
      check("abort_reach_idx10", {26'd0, op_a0, op_b0}, 32'd10);
      abort0 = 1'b1;
      @(posedge clk);
      #1;
      abort0 = 1'b0;
      check("abort_busy", {31'd0, busy0}, 32'd0);
      check("abort_done", {31'd0, done0}, 32'd0);
      e = exp_q.pop_front();
      check("abort_err", {19'd0, err0}, e.err);
      check("abort_max", {25'd0, max0}, e.mx);
      check("abort_sum", {12'd0, sum0}, e.sum);
      sweep(0, 1, 4096, 1'b0);

      sweep(0, 1, 4096, 1'b1);

      // reset in the middle of a sweep with nonzero partial metrics
      mode = 2;
      pulse_start(0);
      w = 0;
      while ({op_a0, op_b0} != 12'd2000 && w < 5000) begin
         @(posedge clk);
         #1;
         w++;
      end
      check("reach_idx2000", {20'd0, op_a0, op_b0}, 32'd2000);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero(0);
      @(negedge clk);
      rst_n = 1'b1;
      sweep(0, 2, 4096, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
